foc_supervisor: RTL and testbench
=================================

// Module: foc_supervisor
// PURPOSE
//  Run-time sequencer for the FOC current-loop core. Owns the core's reset (foc_rstn) and waits out its rotor-alignment phase.
//  Slew-limits the d/q current aims it feeds to the core. Kills PWM on overcurrent, ADC stall or loss of init.
//  Sits between the host/command layer (start/stop/targets) and the FOC core; the core's pwm_en is ANDed with ~pwm_kill.
// PARAMETERS
//  RAMP_STEP    16'd64     max |change| of id_aim/iq_aim per en_idq pulse (1..32767)
//  OC_LIMIT     16'd12000  overcurrent threshold on |id| and |iq| (1..32767)
//  OC_COUNT     8'd4       consecutive over-limit en_idq samples that trip a fault (1..255)
//  ADC_TIMEOUT  16'd512    max clk cycles from sn_adc to en_adc (1..65535)
//  RESET_HOLD   16'd1024   clk cycles foc_rstn is held low on start (1..65535)
// PORTS
//  rstn          in   1    async active-low reset
//  clk           in   1    single clock; all logic on posedge
//  start         in   1    1-cycle pulse: begin run sequence (honoured in IDLE only)
//  stop          in   1    1-cycle pulse: ramp down and return to IDLE
//  fault_clr     in   1    1-cycle pulse: leave FAULT (honoured in FAULT only)
//  id_target     in   16s  requested d-axis current
//  iq_target     in   16s  requested q-axis current
//  foc_rstn      out  1    reset to FOC core (active low)
//  foc_init_done in   1    FOC core alignment finished
//  en_idq        in   1    FOC core id/iq valid pulse
//  id, iq        in   16s  measured d/q currents from the FOC core
//  sn_adc        in   1    FOC core ADC sample strobe
//  en_adc        in   1    ADC conversion-done strobe
//  id_aim        out  16s  slew-limited d aim to the FOC core
//  iq_aim        out  16s  slew-limited q aim to the FOC core
//  pwm_kill      out  1    1 = force all bridge MOSFETs off
//  state         out  3    current state encoding (see below)
//  fault_code    out  2    0 none, 1 overcurrent, 2 ADC timeout, 3 init lost; held until fault_clr
// BEHAVIOUR
//  Reset: state=IDLE, foc_rstn=0, pwm_kill=1, id_aim=iq_aim=0, fault_code=0, all counters=0.
//  States: IDLE=0, RESET=1, ALIGN=2, RUN=3, STOPPING=4, FAULT=5. All outputs are registered, decoded from state.
//    IDLE -start-> RESET.
//    RESET: foc_rstn=0 for RESET_HOLD cycles, then -> ALIGN.
//    ALIGN: foc_rstn=1; foc_init_done=1 -> RUN.
//    RUN: aims ramp toward targets. stop -> STOPPING.
//    STOPPING: aims ramp toward 0. Both aims ==0 -> IDLE.
//    FAULT: fault_clr -> IDLE.
//  stop in RESET/ALIGN -> IDLE next cycle. start outside IDLE, fault_clr outside FAULT: ignored.
//  foc_rstn=1 in ALIGN/RUN/STOPPING, 0 elsewhere. pwm_kill=0 in ALIGN/RUN/STOPPING, 1 elsewhere.
//  Ramp: only in RUN/STOPPING, only on en_idq; aim updated on the cycle after en_idq.
//    diff = tgt - aim in 17-bit signed. diff>STEP: aim+=STEP; diff<-STEP: aim-=STEP; else aim=tgt.
//    Entering RUN or IDLE or FAULT: aims=0.
//  Overcurrent (RUN/STOPPING): on each en_idq, abs of id and iq, with -32768 saturated to 32767.
//    Either abs > OC_LIMIT: oc_cnt++ (saturating); else oc_cnt=0.
//    oc_cnt reaching OC_COUNT -> FAULT code 1 on the next edge.
//  Init lost: foc_init_done==0 while in RUN/STOPPING -> FAULT code 3.
//  FAULT entry: aims forced 0, foc_rstn=0, pwm_kill=1 on the same edge.
//  Priority in one cycle: fault > stop > normal transition. Codes when several trip together: 1 > 2 > 3.
//  Mid-operation rstn assertion: immediate return to the reset values above (async).
// CONFIGURATION
//  FOC_SUPERVISOR_ADC_WDOG_EN defined: ADC watchdog active in RUN/STOPPING.
//    sn_adc (re)starts wdog_cnt at 1; en_adc clears and disarms it.
//    wdog_cnt reaching ADC_TIMEOUT -> FAULT code 2.
//  Undefined: no watchdog logic; sn_adc/en_adc ports remain but are ignored; code 2 never produced.
// STRUCTURE
//  Package foc_sup_pkg: typedef enum logic[2:0] sup_state_t; typedef enum logic[1:0] sup_fault_t; FAULT_* constants.
//  Sub-module foc_slew_limiter (tgt, aim, step, en, zero_req -> aim): instantiated twice, once for d and once for q.
// TESTING
//  start, foc_init_done=1 at cycle 1500 -> foc_rstn low exactly 1024 cycles; state 1->2->3; pwm_kill falls on ALIGN entry.
//  RUN, iq_target=1000, en_idq every 2048 clk -> iq_aim 64,128,...,960,1000; 16th pulse lands exactly on target.
//  RUN, iq=12001 on 3 en_idq then 11999 then 4 more at 12001 -> fault on the 4th consecutive pulse only; code=1, pwm_kill=1, aims=0.
//  ADC_WDOG_EN: sn_adc with no en_adc -> FAULT code 2 exactly 512 cycles later; en_adc at cycle 511 -> no fault.
//  RUN, iq_aim=640, stop -> iq_aim 576..0 over 10 en_idq, then IDLE, foc_rstn=0; stop+fault same cycle -> FAULT.
//  RUN, id=-32768 on 4 en_idq -> code 1 (saturated abs); foc_init_done drop in RUN -> code 3; fault_clr -> IDLE, code 0.

Source files
------------

// File: rtl/foc_sup_pkg.sv
// Package for the FOC supervisor.
// Holds the state and fault-code encodings and a saturating absolute-value
// helper used by the overcurrent check.
package foc_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_ALIGN    = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOPPING = 3'd4,
        ST_FAULT    = 3'd5
    } sup_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'd0,
        FAULT_OC   = 2'd1,
        FAULT_ADC  = 2'd2,
        FAULT_INIT = 2'd3
    } sup_fault_t;

    // |v| as an unsigned 16-bit value. -32768 has no positive twin in 16 bits,
    // so it saturates to 32767.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
        if (v == 16'sh8000) return 16'h7fff;
        else if (v[15])     return ~v + 16'd1;
        else                return v;
    endfunction

endpackage

// File: rtl/foc_slew_limiter.sv
// Combinational slew limiter for one current-aim axis.
// Ports:
//   tgt      in  16s  aim the axis is heading for
//   aim      in  16s  current (registered) aim
//   step     in  16   largest allowed |change| per enabled update
//   en       in  1    apply one ramp step this cycle
//   zero_req in  1    force the next aim to 0 (overrides en)
//   aim_nxt  out 16s  next aim value, registered by the caller
module foc_slew_limiter (
    input  logic signed [15:0] tgt,
    input  logic signed [15:0] aim,
    input  logic        [15:0] step,
    input  logic               en,
    input  logic               zero_req,
    output logic signed [15:0] aim_nxt
);

    // 17 bits so tgt - aim cannot wrap for any pair of 16-bit operands.
    logic signed [16:0] diff;
    logic signed [16:0] step_s;

    always_comb begin
        diff    = {tgt[15], tgt} - {aim[15], aim};
        step_s  = $signed({1'b0, step});
        aim_nxt = aim;
        if (zero_req)              aim_nxt = '0;
        else if (en) begin
            // aim +/- step stays in range: |diff| > step means tgt lies beyond it.
            if (diff > step_s)       aim_nxt = aim + $signed(step);
            else if (diff < -step_s) aim_nxt = aim - $signed(step);
            else                     aim_nxt = tgt;
        end
    end

endmodule

// File: rtl/foc_supervisor.sv
// Run-time sequencer for the FOC current-loop core: owns the core reset,
// waits out rotor alignment, slew-limits the d/q aims and kills PWM on
// overcurrent, ADC stall or loss of init.
// Build option: FOC_SUPERVISOR_ADC_WDOG_EN enables the ADC watchdog
// (sn_adc -> en_adc latency check); without it sn_adc/en_adc are ignored.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   start, stop, fault_clr     1-cycle host command pulses
//   id_target, iq_target       requested d/q currents (16s)
//   foc_rstn                   reset to the FOC core (active low)
//   foc_init_done              core alignment finished
//   en_idq, id, iq             measured d/q currents and their valid pulse
//   sn_adc, en_adc             ADC sample strobe / conversion-done strobe
//   id_aim, iq_aim             slew-limited aims to the core (16s)
//   pwm_kill                   1 = force bridge off
//   state, fault_code          status (state encoding, latched fault cause)
module foc_supervisor
    import foc_sup_pkg::*;
#(
    parameter logic [15:0] RAMP_STEP   = 16'd64,
    parameter logic [15:0] OC_LIMIT    = 16'd12000,
    parameter logic [7:0]  OC_COUNT    = 8'd4,
    parameter logic [15:0] ADC_TIMEOUT = 16'd512,
    parameter logic [15:0] RESET_HOLD  = 16'd1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic               fault_clr,
    input  logic signed [15:0] id_target,
    input  logic signed [15:0] iq_target,
    output logic               foc_rstn,
    input  logic               foc_init_done,
    input  logic               en_idq,
    input  logic signed [15:0] id,
    input  logic signed [15:0] iq,
    input  logic               sn_adc,
    input  logic               en_adc,
    output logic signed [15:0] id_aim,
    output logic signed [15:0] iq_aim,
    output logic               pwm_kill,
    output logic [2:0]         state,
    output logic [1:0]         fault_code
);

    sup_state_t        state_q, state_d;
    sup_fault_t        fault_code_q, fault_code_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [7:0]        oc_cnt_q, oc_cnt_d;
    logic              foc_rstn_q, foc_rstn_d;
    logic              pwm_kill_q, pwm_kill_d;
    logic signed [15:0] id_aim_q, iq_aim_q, id_aim_d, iq_aim_d;

    logic              active, oc_over, oc_trip, adc_trip, init_trip;
    logic              ramp_en, zero_req;
    logic signed [15:0] id_tgt, iq_tgt;

`ifdef FOC_SUPERVISOR_ADC_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
`else
    logic adc_unused;
    assign adc_unused = sn_adc ^ en_adc;
`endif

    assign active  = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    assign oc_over = (abs_sat(id) > OC_LIMIT) || (abs_sat(iq) > OC_LIMIT);
    assign oc_trip   = active && (oc_cnt_q >= OC_COUNT);
    assign init_trip = active && !foc_init_done;
`ifdef FOC_SUPERVISOR_ADC_WDOG_EN
    assign adc_trip  = active && (wdog_cnt_q >= ADC_TIMEOUT);
`else
    assign adc_trip  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        hold_cnt_d   = '0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RESET;
            ST_RESET: begin
                if (stop)                                  state_d = ST_IDLE;
                else if (hold_cnt_q == RESET_HOLD - 16'd1) state_d = ST_ALIGN;
                else                                       hold_cnt_d = hold_cnt_q + 16'd1;
            end
            ST_ALIGN: begin
                if (stop)               state_d = ST_IDLE;
                else if (foc_init_done) state_d = ST_RUN;
            end
            ST_RUN, ST_STOPPING: begin
                if (oc_trip || adc_trip || init_trip) begin
                    state_d      = ST_FAULT;
                    fault_code_d = oc_trip ? FAULT_OC : adc_trip ? FAULT_ADC : FAULT_INIT;
                end else if (state_q == ST_RUN) begin
                    if (stop) state_d = ST_STOPPING;
                end else if (id_aim_q == 16'sd0 && iq_aim_q == 16'sd0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FAULT_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Consecutive over-limit samples; any in-limit sample restarts the run.
        oc_cnt_d = oc_cnt_q;
        if (!active)             oc_cnt_d = '0;
        else if (en_idq) begin
            if (!oc_over)               oc_cnt_d = '0;
            else if (oc_cnt_q != 8'hff) oc_cnt_d = oc_cnt_q + 8'd1;
        end

`ifdef FOC_SUPERVISOR_ADC_WDOG_EN
        // Non-zero count means a conversion is outstanding. A new sample
        // re-arms even if the previous conversion completes in the same cycle.
        wdog_cnt_d = wdog_cnt_q;
        if (!active)                                     wdog_cnt_d = '0;
        else if (sn_adc)                                 wdog_cnt_d = 16'd1;
        else if (en_adc)                                 wdog_cnt_d = '0;
        else if (wdog_cnt_q != '0 && wdog_cnt_q != '1)   wdog_cnt_d = wdog_cnt_q + 16'd1;
`endif

        foc_rstn_d = (state_d == ST_ALIGN) || (state_d == ST_RUN) || (state_d == ST_STOPPING);
        pwm_kill_d = !foc_rstn_d;

        // Aims clear on any exit from RUN/STOPPING and on fresh RUN entry.
        ramp_en  = active && en_idq;
        zero_req = !((state_d == ST_RUN) || (state_d == ST_STOPPING)) ||
                   ((state_d == ST_RUN) && (state_q != ST_RUN));
        id_tgt   = (state_q == ST_STOPPING) ? 16'sd0 : id_target;
        iq_tgt   = (state_q == ST_STOPPING) ? 16'sd0 : iq_target;
    end

    foc_slew_limiter u_slew_d (
        .tgt(id_tgt), .aim(id_aim_q), .step(RAMP_STEP),
        .en(ramp_en), .zero_req(zero_req), .aim_nxt(id_aim_d)
    );

    foc_slew_limiter u_slew_q (
        .tgt(iq_tgt), .aim(iq_aim_q), .step(RAMP_STEP),
        .en(ramp_en), .zero_req(zero_req), .aim_nxt(iq_aim_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FAULT_NONE;
            hold_cnt_q   <= '0;
            oc_cnt_q     <= '0;
            foc_rstn_q   <= 1'b0;
            pwm_kill_q   <= 1'b1;
            id_aim_q     <= '0;
            iq_aim_q     <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            hold_cnt_q   <= hold_cnt_d;
            oc_cnt_q     <= oc_cnt_d;
            foc_rstn_q   <= foc_rstn_d;
            pwm_kill_q   <= pwm_kill_d;
            id_aim_q     <= id_aim_d;
            iq_aim_q     <= iq_aim_d;
        end
    end

`ifdef FOC_SUPERVISOR_ADC_WDOG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wdog_cnt_q <= '0;
        else       wdog_cnt_q <= wdog_cnt_d;
    end
`endif

    assign state      = state_q;
    assign fault_code = fault_code_q;
    assign foc_rstn   = foc_rstn_q;
    assign pwm_kill   = pwm_kill_q;
    assign id_aim     = id_aim_q;
    assign iq_aim     = iq_aim_q;

endmodule

// File: tb/tb_foc_supervisor.sv
// Bench for foc_supervisor: directed sequencing plus randomized ramp traffic.
// Aim updates are predicted by a reference model and queued; a monitor pops
// and compares on the cycle after every en_idq pulse.
module tb_foc_supervisor;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 0, stop = 0, fault_clr = 0;
    logic signed [15:0] id_target = 0, iq_target = 0;
    logic foc_rstn;
    logic foc_init_done = 0;
    logic en_idq = 0;
    logic signed [15:0] id = 0, iq = 0;
    logic sn_adc = 0, en_adc = 0;
    logic signed [15:0] id_aim, iq_aim;
    logic pwm_kill;
    logic [2:0] state;
    logic [1:0] fault_code;

    always #5 clk = ~clk;

    foc_supervisor dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .fault_clr(fault_clr),
        .id_target(id_target), .iq_target(iq_target), .foc_rstn(foc_rstn),
        .foc_init_done(foc_init_done), .en_idq(en_idq), .id(id), .iq(iq),
        .sn_adc(sn_adc), .en_adc(en_adc), .id_aim(id_aim), .iq_aim(iq_aim),
        .pwm_kill(pwm_kill), .state(state), .fault_code(fault_code)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int  m_id = 0, m_iq = 0;
    bit  m_stopping = 0;
    bit  mon_en = 0;
    int  q_id[$];
    int  q_iq[$];
    bit  pend = 0;

    // Move toward tgt by at most 64 per update, landing exactly on it when close.
    function automatic int step_to(input int aim, input int tgt);
        if (tgt - aim > 64)  return aim + 64;
        if (aim - tgt > 64)  return aim - 64;
        return tgt;
    endfunction

    always @(posedge clk) pend <= en_idq && mon_en;

    always @(negedge clk) begin
        if (pend) begin
            if (q_id.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: aim update seen with no expectation queued");
            end else begin
                int e_id, e_iq;
                e_id = q_id.pop_front();
                e_iq = q_iq.pop_front();
                chk("sb_id_aim", int'(id_aim), e_id);
                chk("sb_iq_aim", int'(iq_aim), e_iq);
            end
        end
    end

    task automatic pulse(input int idv, input int iqv);
        repeat ($urandom_range(1, 12)) @(negedge clk);
        id = 16'(idv); iq = 16'(iqv); en_idq = 1;
        if (mon_en) begin
            m_id = step_to(m_id, m_stopping ? 0 : int'(id_target));
            m_iq = step_to(m_iq, m_stopping ? 0 : int'(iq_target));
            q_id.push_back(m_id);
            q_iq.push_back(m_iq);
        end
        @(negedge clk);
        en_idq = 0;
    endtask

    task automatic cmd(input int which);   // 0 start, 1 stop, 2 fault_clr
        @(negedge clk);
        if (which == 0) start = 1; else if (which == 1) stop = 1; else fault_clr = 1;
        @(negedge clk);
        start = 0; stop = 0; fault_clr = 0;
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (int'(state) != s && n < 5000) begin @(negedge clk); n++; end
        chk(name, int'(state), s);
    endtask

    task automatic go_run();
        int n = 0;
        foc_init_done = 0;
        cmd(0);
        wait_state(1, "enter_reset");
        chk("reset_foc_rstn", int'(foc_rstn), 0);
        while (state == 3'd1 && n < 5000) begin @(negedge clk); n++; end
        chk("reset_len", n, 1024);
        chk("align_state", int'(state), 2);
        chk("align_foc_rstn", int'(foc_rstn), 1);
        chk("align_pwm_kill", int'(pwm_kill), 0);
        repeat ($urandom_range(5, 20)) @(negedge clk);
        chk("align_wait", int'(state), 2);
        foc_init_done = 1;
        @(negedge clk);
        chk("run_state", int'(state), 3);
        chk("run_entry_iq_aim", int'(iq_aim), 0);
        m_id = 0; m_iq = 0; m_stopping = 0;
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rstn = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_foc_rstn", int'(foc_rstn), 0);
        chk("rst_pwm_kill", int'(pwm_kill), 1);
        chk("rst_aims", int'(id_aim) | int'(iq_aim), 0);
        chk("rst_code", int'(fault_code), 0);
        rstn = 1;
        @(negedge clk);

        // fault_clr outside FAULT is ignored
        cmd(2);
        chk("clr_in_idle", int'(state), 0);

        // ---- bring-up and ramp to 1000 in 16 steps ----
        go_run();
        mon_en = 1;
        iq_target = 16'sd1000;
        for (int k = 0; k < 16; k++) pulse(0, 0);
        chk("iq_on_target", int'(iq_aim), 1000);

        // ---- random targets ----
        for (int r = 0; r < 5; r++) begin
            id_target = 16'(int'($urandom_range(0, 40000)) - 20000);
            iq_target = 16'(int'($urandom_range(0, 40000)) - 20000);
            for (int k = 0; k < 12; k++)
                pulse(int'($urandom_range(0, 20000)) - 10000, int'($urandom_range(0, 20000)) - 10000);
        end
        cmd(0);
        chk("start_in_run_ignored", int'(state), 3);

        // ---- overcurrent: a single in-limit sample breaks the run ----
        id_target = 16'(m_id); iq_target = 16'(m_iq);
        for (int k = 0; k < 3; k++) pulse(int'($urandom_range(0, 2000)), 12001);
        pulse(0, 11999);
        for (int k = 0; k < 3; k++) pulse(0, 12001);
        repeat (2) @(negedge clk);
        chk("oc_three_no_trip", int'(state), 3);
        pulse(0, -12001);
        @(negedge clk);
        chk("oc_fault_state", int'(state), 5);
        chk("oc_fault_code", int'(fault_code), 1);
        chk("oc_pwm_kill", int'(pwm_kill), 1);
        chk("oc_foc_rstn", int'(foc_rstn), 0);
        chk("oc_aims_zero", int'(id_aim) | int'(iq_aim), 0);
        cmd(0);
        chk("start_in_fault_ignored", int'(state), 5);
        cmd(2);
        chk("clr_state", int'(state), 0);
        chk("clr_code", int'(fault_code), 0);

        // ---- stop ramps down then returns to IDLE ----
        id_target = 0; iq_target = 16'sd640;
        go_run();
        for (int k = 0; k < 10; k++) pulse(0, 0);
        chk("pre_stop_iq", int'(iq_aim), 640);
        cmd(1);
        m_stopping = 1;
        chk("stopping_state", int'(state), 4);
        for (int k = 0; k < 10; k++) pulse(0, 0);
        @(negedge clk);
        chk("stop_idle", int'(state), 0);
        chk("stop_foc_rstn", int'(foc_rstn), 0);
        chk("stop_pwm_kill", int'(pwm_kill), 1);
        m_stopping = 0;

        // ---- saturated abs on -32768 ----
        iq_target = 0;
        go_run();
        for (int k = 0; k < 3; k++) pulse(-32768, 0);
        repeat (2) @(negedge clk);
        chk("sat_three_no_trip", int'(state), 3);
        pulse(-32768, 0);
        @(negedge clk);
        chk("sat_fault_state", int'(state), 5);
        chk("sat_fault_code", int'(fault_code), 1);
        cmd(2);

        // ---- stop and init loss in the same cycle: fault wins ----
        go_run();
        @(negedge clk);
        stop = 1; foc_init_done = 0;
        @(negedge clk);
        stop = 0;
        chk("prio_state", int'(state), 5);
        chk("prio_code", int'(fault_code), 3);
        chk("prio_code_held", int'(fault_code), 3);
        cmd(2);
        chk("prio_clr", int'(state), 0);

        // ---- stop during RESET ----
        foc_init_done = 0;
        cmd(0);
        wait_state(1, "reset_for_stop");
        repeat (10) @(negedge clk);
        cmd(1);
        chk("stop_in_reset", int'(state), 0);

        // ---- ADC watchdog ----
        go_run();
`ifdef FOC_SUPERVISOR_ADC_WDOG_EN
        @(negedge clk); sn_adc = 1; @(negedge clk); sn_adc = 0;
        repeat (510) @(negedge clk);
        en_adc = 1; @(negedge clk); en_adc = 0;
        repeat (100) @(negedge clk);
        chk("wdog_served", int'(state), 3);
        @(negedge clk); sn_adc = 1; @(negedge clk); sn_adc = 0;
        repeat (511) @(negedge clk);
        chk("wdog_511", int'(state), 3);
        @(negedge clk);
        chk("wdog_trip", int'(state), 5);
        chk("wdog_code", int'(fault_code), 2);
        cmd(2);
        go_run();
`else
        @(negedge clk); sn_adc = 1; @(negedge clk); sn_adc = 0;
        repeat (600) @(negedge clk);
        chk("wdog_absent", int'(state), 3);
`endif

        // ---- async reset mid-run ----
        iq_target = 16'sd300;
        for (int k = 0; k < 3; k++) pulse(0, 0);
        chk("pre_rst_iq", int'(iq_aim), 192);
        @(negedge clk);
        #2 rstn = 0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_pwm_kill", int'(pwm_kill), 1);
        chk("arst_foc_rstn", int'(foc_rstn), 0);
        chk("arst_iq_aim", int'(iq_aim), 0);
        @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);
        chk("sb_empty", q_id.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
